// File: rtl/ros2_sub_msg_reader_if.sv
// Signal bundle between the ros2_ether subscriber port, the message reader and the byte consumer.
// master = core / consumer side, slave = ros2_sub_msg_reader.
interface ros2_sub_msg_reader_if #(
    parameter int AWIDTH = 6
);
    logic [AWIDTH-1:0] sub_addr;
    logic              sub_ce;
    logic              sub_we;
    logic [7:0]        sub_wdata;
    logic [7:0]        sub_len;
    logic [15:0]       sub_rep_id;
    logic              sub_recv;
    logic              sub_req;
    logic              sub_grant;
    logic              sub_rel;
    logic [7:0]        m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              err;
    logic [7:0]        drop_cnt;

    modport master (
        output sub_addr, sub_ce, sub_we, sub_wdata, sub_len, sub_rep_id, sub_recv, sub_grant, m_ready,
        input  sub_req, sub_rel, m_data, m_valid, m_last, err, drop_cnt
    );

    modport slave (
        input  sub_addr, sub_ce, sub_we, sub_wdata, sub_len, sub_rep_id, sub_recv, sub_grant, m_ready,
        output sub_req, sub_rel, m_data, m_valid, m_last, err, drop_cnt
    );
endinterface

// File: rtl/ros2_sub_msg_reader.sv
// ROS2 subscriber consumer: owns the message store, claims it via req/grant/rel, decodes a CDR
// std_msgs/String and streams its characters. Optional macro ROS2_SUB_REP_ID_FILTER_EN adds a rep-id check.
module ros2_sub_msg_reader #(
    parameter int          MAX_APP_DATA_LEN = 64,
    parameter int          AWIDTH           = $clog2(MAX_APP_DATA_LEN),
    parameter logic [15:0] REP_ID_CDR_LE    = 16'h0001
) (
    input logic                  clk,
    input logic                  rst_n,
    ros2_sub_msg_reader_if.slave bus
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REQ    = 3'd1;
    localparam logic [2:0] ST_HDR    = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_STREAM = 3'd4;
    localparam logic [2:0] ST_REL    = 3'd5;

    logic [7:0]        mem [MAX_APP_DATA_LEN];
    logic [7:0]        rd_data_r;
    logic [AWIDTH-1:0] rd_addr_s;

    logic [2:0]        state_r;
    logic [2:0]        state_nxt_s;
    logic              pending_r;
    logic [7:0]        len_r;
    logic [7:0]        drop_cnt_r;
    logic [31:0]       strlen_r;
    logic [2:0]        hdr_cnt_r;

    logic [AWIDTH-1:0] fetch_ptr_r;
    logic [AWIDTH-1:0] last_addr_s;
    logic              fetch_done_r;
    logic              inflight_r;
    logic              inflight_last_r;
    logic              sk_vld_r;
    logic              sk_last_r;
    logic [7:0]        sk_data_r;
    logic [7:0]        m_data_r;
    logic              m_valid_r;
    logic              m_last_r;
    logic              sub_req_r;
    logic              sub_rel_r;
    logic              err_r;

    logic              accept_s;
    logic              pop_s;
    logic              issue_s;
    logic              out_free_s;
    logic              done_s;
    logic [1:0]        occ_s;

`ifdef ROS2_SUB_REP_ID_FILTER_EN
    logic [15:0]       rep_id_r;

    // Representation identifier captured with each notification.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_id_r <= 16'h0000;
        end else if (bus.sub_recv) begin
            rep_id_r <= bus.sub_rep_id;
        end else begin
            rep_id_r <= rep_id_r;
        end
    end
`else
    logic              rep_id_unused_s;
    assign rep_id_unused_s = ^{bus.sub_rep_id, REP_ID_CDR_LE};
`endif

    // Byte store: core write port plus a registered internal read port.
    always_ff @(posedge clk) begin
        if (bus.sub_ce && bus.sub_we) begin
            mem[bus.sub_addr] <= bus.sub_wdata;
        end
        rd_data_r <= mem[rd_addr_s];
    end

    // Read address: header bytes while decoding, prefetch pointer otherwise.
    always_comb begin
        rd_addr_s = fetch_ptr_r;
        if (state_r == ST_HDR) begin
            rd_addr_s = AWIDTH'(hdr_cnt_r[1:0]);
        end else begin
            rd_addr_s = fetch_ptr_r;
        end
    end

    // Acceptance test uses 33-bit arithmetic so a huge strlen cannot wrap past the length check.
    always_comb begin
        accept_s = (strlen_r != 32'd0)
                && (({1'b0, strlen_r} + 33'd4) <= {25'd0, len_r})
                && ({25'd0, len_r} <= 33'(MAX_APP_DATA_LEN));
`ifdef ROS2_SUB_REP_ID_FILTER_EN
        accept_s = accept_s && (rep_id_r == REP_ID_CDR_LE);
`endif
    end

    // Stream pipeline control: out register + skid slot + one read in flight, at most two bytes owned.
    always_comb begin
        pop_s       = m_valid_r && bus.m_ready;
        out_free_s  = !m_valid_r || bus.m_ready;
        done_s      = pop_s && m_last_r;
        occ_s       = {1'b0, m_valid_r} + {1'b0, sk_vld_r} + {1'b0, inflight_r};
        issue_s     = (state_r == ST_STREAM) && !fetch_done_r && ((occ_s - {1'b0, pop_s}) <= 2'd1);
        last_addr_s = strlen_r[AWIDTH-1:0] + AWIDTH'(2);
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:   state_nxt_s = pending_r ? ST_REQ : ST_IDLE;
            ST_REQ:    state_nxt_s = bus.sub_grant ? ST_HDR : ST_REQ;
            ST_HDR:    state_nxt_s = (hdr_cnt_r == 3'd4) ? ST_CHECK : ST_HDR;
            ST_CHECK:  state_nxt_s = (!accept_s || (strlen_r == 32'd1)) ? ST_REL : ST_STREAM;
            ST_STREAM: state_nxt_s = done_s ? ST_REL : ST_STREAM;
            ST_REL:    state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Control registers, notification capture, header assembly and stream datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            pending_r       <= 1'b0;
            len_r           <= 8'd0;
            drop_cnt_r      <= 8'd0;
            strlen_r        <= 32'd0;
            hdr_cnt_r       <= 3'd0;
            sub_req_r       <= 1'b0;
            sub_rel_r       <= 1'b0;
            err_r           <= 1'b0;
            fetch_ptr_r     <= AWIDTH'(4);
            fetch_done_r    <= 1'b0;
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
            sk_vld_r        <= 1'b0;
            sk_last_r       <= 1'b0;
            sk_data_r       <= 8'd0;
            m_data_r        <= 8'd0;
            m_valid_r       <= 1'b0;
            m_last_r        <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            sub_req_r <= (state_nxt_s inside {ST_REQ, ST_HDR, ST_CHECK, ST_STREAM});
            sub_rel_r <= (state_nxt_s == ST_REL);
            err_r     <= (state_r == ST_CHECK) && !accept_s;

            // A new notification always wins over IDLE consuming the old one.
            if (bus.sub_recv) begin
                len_r     <= bus.sub_len;
                pending_r <= 1'b1;
                if ((state_r != ST_IDLE) && pending_r && (drop_cnt_r != 8'hFF)) begin
                    drop_cnt_r <= drop_cnt_r + 8'd1;
                end
            end else if (state_r == ST_IDLE) begin
                pending_r <= 1'b0;
            end

            if (state_r == ST_HDR) begin
                hdr_cnt_r <= hdr_cnt_r + 3'd1;
                case (hdr_cnt_r)
                    3'd1:    strlen_r[7:0]   <= rd_data_r;
                    3'd2:    strlen_r[15:8]  <= rd_data_r;
                    3'd3:    strlen_r[23:16] <= rd_data_r;
                    3'd4:    strlen_r[31:24] <= rd_data_r;
                    default: strlen_r        <= strlen_r;
                endcase
            end else begin
                hdr_cnt_r <= 3'd0;
            end

            if (state_r == ST_STREAM) begin
                if (issue_s) begin
                    if (fetch_ptr_r == last_addr_s) begin
                        fetch_done_r <= 1'b1;
                    end else begin
                        fetch_ptr_r <= fetch_ptr_r + AWIDTH'(1);
                    end
                end
                inflight_r      <= issue_s;
                inflight_last_r <= issue_s && (fetch_ptr_r == last_addr_s);
                if (out_free_s) begin
                    if (sk_vld_r) begin
                        m_data_r  <= sk_data_r;
                        m_last_r  <= sk_last_r;
                        m_valid_r <= 1'b1;
                        sk_vld_r  <= inflight_r;
                        if (inflight_r) begin
                            sk_data_r <= rd_data_r;
                            sk_last_r <= inflight_last_r;
                        end
                    end else if (inflight_r) begin
                        m_data_r  <= rd_data_r;
                        m_last_r  <= inflight_last_r;
                        m_valid_r <= 1'b1;
                    end else begin
                        m_valid_r <= 1'b0;
                        m_last_r  <= 1'b0;
                    end
                end else if (inflight_r) begin
                    sk_data_r <= rd_data_r;
                    sk_last_r <= inflight_last_r;
                    sk_vld_r  <= 1'b1;
                end
            end else begin
                fetch_ptr_r     <= AWIDTH'(4);
                fetch_done_r    <= 1'b0;
                inflight_r      <= 1'b0;
                inflight_last_r <= 1'b0;
                sk_vld_r        <= 1'b0;
                sk_last_r       <= 1'b0;
                m_valid_r       <= 1'b0;
                m_last_r        <= 1'b0;
            end
        end
    end

    assign bus.sub_req  = sub_req_r;
    assign bus.sub_rel  = sub_rel_r;
    assign bus.m_data   = m_data_r;
    assign bus.m_valid  = m_valid_r;
    assign bus.m_last   = m_last_r;
    assign bus.err      = err_r;
    assign bus.drop_cnt = drop_cnt_r;
endmodule

// File: tb/tb_ros2_sub_msg_reader.sv
// Self-checking bench for ros2_sub_msg_reader: behavioural message model (expected byte queue,
// release/error/drop counts) compared every cycle against the DUT stream.
module tb_ros2_sub_msg_reader;
`ifdef ROS2_SUB_REP_ID_FILTER_EN
    localparam bit REP_FILTER = 1'b1;
`else
    localparam bit REP_FILTER = 1'b0;
`endif

    logic clk;
    logic rst_n;

    ros2_sub_msg_reader_if #(.AWIDTH(6)) bus ();

    ros2_sub_msg_reader #(
        .MAX_APP_DATA_LEN(64),
        .AWIDTH(6),
        .REP_ID_CDR_LE(16'h0001)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state
    logic [7:0] mem_model [64];
    logic [8:0] exp_q [$];
    int exp_rel = 0;
    int exp_err = 0;
    int exp_beats = 0;
    int exp_drop = 0;

    // observed state
    int cyc = 0;
    int rel_seen = 0;
    int err_seen = 0;
    int beats = 0;
    int msg_beat = 0;
    int rel_lat = 0;
    int t0 = 0;
    bit in_grant = 1'b0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic prev_last;
    logic [7:0] first_byte;
    logic [7:0] last_byte;

    int grant_delay = 3;
    int ready_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // core side: grant after grant_delay cycles of request, drop it on release
    initial begin : core_grant
        int waitc;
        waitc = 0;
        bus.sub_grant = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || bus.sub_rel) begin
                bus.sub_grant = 1'b0;
                waitc = 0;
            end else if (bus.sub_req && !bus.sub_grant) begin
                if (waitc >= grant_delay) begin
                    bus.sub_grant = 1'b1;
                    waitc = 0;
                end else begin
                    waitc++;
                end
            end
        end
    end

    // consumer ready pattern: 0 always ready, 1 toggling, 2 random
    initial begin : consumer_ready
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       bus.m_ready = ~bus.m_ready;
                2:       bus.m_ready = 1'($urandom_range(0, 1));
                default: bus.m_ready = 1'b1;
            endcase
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_stall = 1'b0;
            in_grant = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", bus.m_valid, 1);
                chk("stall_data", bus.m_data, prev_data);
                chk("stall_last", bus.m_last, prev_last);
            end
            if (bus.m_valid && bus.m_ready) begin
                chk("byte_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("stream_data", bus.m_data, e[7:0]);
                    chk("stream_last", bus.m_last, e[8]);
                end
                if (msg_beat == 0) first_byte = bus.m_data;
                last_byte = bus.m_data;
                msg_beat++;
                beats++;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data = bus.m_data;
            prev_last = bus.m_last;
            if (bus.err) begin
                err_seen++;
                chk("err_with_rel", bus.sub_rel, 1);
            end
            if (bus.sub_req && bus.sub_grant && !in_grant) begin
                in_grant = 1'b1;
                t0 = cyc;
            end
            if (bus.sub_rel) begin
                rel_seen++;
                rel_lat = cyc - t0;
                in_grant = 1'b0;
                msg_beat = 0;
                chk("req_low_at_rel", bus.sub_req, 0);
            end
        end
    end

    task automatic put_byte(input int a, input logic [7:0] d);
        mem_model[a] = d;
        bus.sub_addr = 6'(a);
        bus.sub_wdata = d;
        bus.sub_ce = 1'b1;
        bus.sub_we = 1'b1;
        tick();
        bus.sub_ce = 1'b0;
        bus.sub_we = 1'b0;
    endtask

    task automatic put_hdr(input logic [31:0] slf);
        put_byte(0, slf[7:0]);
        put_byte(1, slf[15:8]);
        put_byte(2, slf[23:16]);
        put_byte(3, slf[31:24]);
    endtask

    task automatic load_str(input logic [31:0] slf, input string s);
        put_hdr(slf);
        for (int i = 0; i < s.len(); i++) put_byte(4 + i, s[i]);
        if (4 + s.len() < 64) put_byte(4 + s.len(), 8'h00);
    endtask

    task automatic load_rand(input logic [31:0] slf, input int nch);
        put_hdr(slf);
        for (int i = 0; i < nch && 4 + i < 64; i++) put_byte(4 + i, 8'($urandom_range(32, 126)));
        if (4 + nch < 64) put_byte(4 + nch, 8'h00);
    endtask

    // decode the stored message from the CDR rules and queue what the DUT must produce
    task automatic model_msg(input int len, input logic [15:0] rep);
        longint sl;
        bit ok;
        sl = 0;
        sl[31:0] = {mem_model[3], mem_model[2], mem_model[1], mem_model[0]};
        ok = (sl >= 1) && (sl + 4 <= len) && (len <= 64);
        ok = ok && (!REP_FILTER || rep == 16'h0001);
        exp_rel++;
        if (ok) begin
            for (int i = 0; i < sl - 1; i++) begin
                exp_q.push_back({(i == sl - 2), mem_model[4 + i]});
                exp_beats++;
            end
        end else begin
            exp_err++;
        end
    endtask

    task automatic notify(input int len, input logic [15:0] rep);
        bus.sub_len = 8'(len);
        bus.sub_rep_id = rep;
        bus.sub_recv = 1'b1;
        tick();
        bus.sub_recv = 1'b0;
    endtask

    task automatic send(input int len, input logic [15:0] rep);
        notify(len, rep);
        model_msg(len, rep);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!(rel_seen == exp_rel && exp_q.size() == 0 && !bus.sub_req) && n < 4000) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, (n < 4000), 1);
        repeat (3) tick();
        chk({name, "_rel"}, rel_seen, exp_rel);
        chk({name, "_err"}, err_seen, exp_err);
        chk({name, "_beats"}, beats, exp_beats);
        chk({name, "_drop"}, bus.drop_cnt, exp_drop);
    endtask

    initial begin : main
        int b0;
        int e0;
        int r0;
        int n;
        for (int i = 0; i < 64; i++) mem_model[i] = 8'h00;
        rst_n = 1'b0;
        bus.sub_addr = 6'd0;
        bus.sub_ce = 1'b0;
        bus.sub_we = 1'b0;
        bus.sub_wdata = 8'd0;
        bus.sub_len = 8'd0;
        bus.sub_rep_id = 16'h0001;
        bus.sub_recv = 1'b0;
        repeat (3) tick();
        chk("rst_sub_req", bus.sub_req, 0);
        chk("rst_sub_rel", bus.sub_rel, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_last", bus.m_last, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_drop_cnt", bus.drop_cnt, 0);
        rst_n = 1'b1;
        tick();

        // basic message
        grant_delay = 3;
        ready_mode = 0;
        load_str(32'd22, "Message From FPGA - 0");
        b0 = beats; e0 = err_seen; r0 = rel_seen;
        send(26, 16'h0001);
        wait_done("basic");
        chk("basic_count", beats - b0, 21);
        chk("basic_first", first_byte, 8'h4D);
        chk("basic_last", last_byte, 8'h30);
        chk("basic_one_rel", rel_seen - r0, 1);
        chk("basic_no_err", err_seen - e0, 0);

        // backpressure
        ready_mode = 1;
        b0 = beats;
        send(26, 16'h0001);
        wait_done("bp");
        chk("bp_count", beats - b0, 21);
        chk("bp_last", last_byte, 8'h30);
        ready_mode = 0;

        // length errors
        b0 = beats; e0 = err_seen;
        load_str(32'd0, "abc");
        send(26, 16'h0001);
        wait_done("strlen0");
        load_str(32'd22, "Message From FPGA - 0");
        send(80, 16'h0001);
        wait_done("len80");
        load_str(32'd30, "Message From FPGA - 0");
        send(26, 16'h0001);
        wait_done("strlen30");
        load_str(32'hFFFF_FFFE, "wrap");
        send(26, 16'h0001);
        wait_done("wrap");
        chk("lenerr_errs", err_seen - e0, 4);
        chk("lenerr_no_bytes", beats - b0, 0);
        chk("wrap_rel_lat", rel_lat, 7);

        // minimal string
        b0 = beats; e0 = err_seen;
        load_str(32'd1, "");
        send(5, 16'h0001);
        wait_done("minimal");
        chk("min_no_bytes", beats - b0, 0);
        chk("min_no_err", err_seen - e0, 0);
        chk("min_rel_lat", rel_lat, 7);

        // largest accepted message
        b0 = beats;
        load_rand(32'd60, 59);
        send(64, 16'h0001);
        wait_done("max");
        chk("max_count", beats - b0, 59);

        // notifications while busy collapse into one further message
        b0 = beats; r0 = rel_seen;
        load_str(32'd22, "Message From FPGA - 0");
        send(26, 16'h0001);
        n = 0;
        while (!bus.m_valid && n < 200) begin
            tick();
            n++;
        end
        chk("busy_stream_timeout", (n < 200), 1);
        notify(26, 16'h0001);
        tick();
        notify(26, 16'h0001);
        tick();
        notify(26, 16'h0001);
        model_msg(26, 16'h0001);
        exp_drop = 2;
        wait_done("busy");
        chk("busy_drop_cnt", bus.drop_cnt, 2);
        chk("busy_rels", rel_seen - r0, 2);
        chk("busy_count", beats - b0, 42);

`ifdef ROS2_SUB_REP_ID_FILTER_EN
        b0 = beats; e0 = err_seen;
        send(26, 16'h0001);
        wait_done("rep_ok");
        chk("rep_ok_count", beats - b0, 21);
        send(26, 16'h0003);
        wait_done("rep_bad");
        chk("rep_bad_err", err_seen - e0, 1);
        chk("rep_bad_count", beats - b0, 21);
`endif

        // randomized messages
        ready_mode = 2;
        for (int k = 0; k < 20; k++) begin
            int sl;
            int len;
            logic [15:0] rep;
            grant_delay = $urandom_range(0, 5);
            rep = REP_FILTER ? (($urandom_range(0, 3) == 0) ? 16'h0003 : 16'h0001) : 16'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                sl = $urandom_range(1, 40);
                len = sl + 4 + $urandom_range(0, 8);
            end else begin
                sl = $urandom_range(0, 70);
                len = $urandom_range(0, 100);
            end
            load_rand(32'(sl), (sl > 0) ? sl - 1 : 0);
            send(len, rep);
            wait_done("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ros2_sub_msg_reader.md
Name: ros2_sub_msg_reader

Overview:
- Application-side consumer for the ROS2 subscriber path; the receive-side counterpart of the publisher message-control logic in our top-levels.
- Provides the byte store that the ros2_ether subscriber write port fills.
- Arbitrates buffer ownership through the sub req/grant/rel handshake, then decodes the CDR std_msgs/String payload.
- Emits the string characters as a valid/ready byte stream for LEDs, a UART bridge or other user logic.

Parameters:
- MAX_APP_DATA_LEN, 64: depth in bytes of the local message store; matches the core's maximum application data length.
- AWIDTH, $clog2(MAX_APP_DATA_LEN): address width.
- REP_ID_CDR_LE, 16'h0001: accepted representation identifier; used only with the optional feature.

Ports:
- clk  in  1  clock, same domain as ros2_ether.
- rst_n  in  1  synchronous, active-low reset.
- sub_addr  in  AWIDTH  byte address from core.
- sub_ce  in  1  write-port chip enable.
- sub_we  in  1  write enable.
- sub_wdata  in  8  write data.
- sub_len  in  8  application data length in bytes, valid when sub_recv pulses.
- sub_rep_id  in  16  representation identifier, valid when sub_recv pulses.
- sub_recv  in  1  one-cycle pulse: a complete message is now in the store.
- sub_req  out  1  request buffer ownership.
- sub_grant  in  1  core grants ownership; core performs no writes while it is high.
- sub_rel  out  1  one-cycle release pulse.
- m_data  out  8  string byte.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  final byte of the string.
- err  out  1  one-cycle pulse: message rejected.
- drop_cnt  out  8  saturating count of collapsed notifications.

Behaviour:
- Store: MAX_APP_DATA_LEN x 8 array.
  - Written on sub_ce & sub_we at sub_addr.
  - Not reset.
  - Internal read is registered, 1-cycle latency.
- On sub_recv: capture sub_len and sub_rep_id into registers and set a pending flag.
- States: IDLE, REQ, HDR, CHECK, STREAM, REL.
- IDLE: if pending, clear pending and go to REQ.
- REQ: sub_req=1; wait for sub_grant=1, then go to HDR.
- HDR:
  - Read bytes 0..3 and assemble strlen as a little-endian 32-bit value (byte 0 = LSB).
  - Takes 5 cycles including read latency.
- CHECK (1 cycle): accept when all hold:
  - strlen >= 1
  - strlen + 4 <= len_reg
  - len_reg <= MAX_APP_DATA_LEN
  - Arithmetic is 33-bit; no wrap.
  - Accept -> STREAM. Reject -> pulse err, go to REL.
- STREAM:
  - Emit bytes 4 .. 4+strlen-2, i.e. strlen-1 bytes; the trailing NUL is not emitted.
  - strlen==1 emits nothing and goes straight to REL.
  - AXI-style rules: m_data and m_last stable while m_valid & !m_ready; m_valid never drops without a handshake.
  - m_last=1 on the final byte.
  - Prefetch the next byte so full throughput is 1 byte/cycle when m_ready is held high.
- REL:
  - sub_rel=1 for exactly one cycle.
  - sub_req deasserts in the same cycle.
  - Next state IDLE.
- sub_recv while not IDLE:
  - If pending is already set, drop_cnt increments, saturating at 255.
  - The pending flag is set either way; the newest sub_len/sub_rep_id overwrite the captured values.
- sub_recv in the same cycle IDLE consumes pending: the new event stays pending.
- sub_grant is assumed held until sub_rel; it is not rechecked after REQ.
- Reset values:
  - sub_req=0, sub_rel=0, m_valid=0, m_last=0, m_data=0, err=0, drop_cnt=0.
  - pending=0, state IDLE.
- Reset mid-operation aborts immediately with no sub_rel pulse. The core is reset together with this block.

Optional Feature:
- Macro: ROS2_SUB_REP_ID_FILTER_EN.
- Defined: CHECK also requires rep_id_reg == REP_ID_CDR_LE; a mismatch pulses err and goes to REL.
- Undefined: sub_rep_id is ignored and no rep_id register is synthesised.

Test Plan:
- Basic message:
  - Stimulus: write "Message From FPGA - 0" with CDR header 0x16,0,0,0 (strlen 22), sub_len=26, pulse sub_recv, grant after 3 cycles.
  - Response: 21 bytes, first 0x4D, last 0x30 with m_last; exactly one sub_rel; err=0.
- Backpressure:
  - Stimulus: same message with m_ready toggling 1010...
  - Response: byte order unchanged; m_data stable while stalled; still 21 bytes.
- Length errors:
  - strlen=0 -> err pulse, no m_valid, sub_rel.
  - sub_len=80 -> err.
  - strlen=30 with sub_len=26 -> err.
- Notification while busy:
  - Stimulus: sub_recv during STREAM, then two more.
  - Response: drop_cnt=2; one further message is processed after REL.
- Minimal string: strlen=1 -> no stream output, sub_rel one cycle after CHECK.
- With ROS2_SUB_REP_ID_FILTER_EN defined:
  - sub_rep_id=16'h0001 -> streamed.
  - sub_rep_id=16'h0003 -> err pulse, no stream.
